// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice:
//     - ALU opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR)
//     - arbiter FSM state type
//     - requester identifier type (0 = core control, 1 = address/aux unit)
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

  // Opcode values as seen on alu.mode. They are zero-extended or truncated
  // to the datapath width at the point of use.
  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_AUX  = 1'b1
  } req_id_e;

endpackage

// File: rtl/alu_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way grant generator for the ALU arbiter.
//   Default build: round-robin. On a tie the requester that was not granted
//   last wins; the last-grant pointer resets to REQ_AUX so requester 0 wins
//   the first tie.
//   With ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always
//   wins ties and no pointer register exists.
//
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   valid_i     in   [1:0] request valids, bit i = requester i
//   advance_i   in   grant was accepted this cycle (updates the pointer)
//   grant_o     out  [1:0] one-hot (or zero) grant
//   grant_id_o  out  identifier of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output req_id_e    grant_id_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Pure combinational priority: clock, reset and advance have no role.
  logic unused_rr;
  assign unused_rr = ^{clk, rst, advance_i};

  always_comb begin
    grant_o = 2'b00;
    if (valid_i[0]) begin
      grant_o = 2'b01;
    end else if (valid_i[1]) begin
      grant_o = 2'b10;
    end
  end

`else

  req_id_e last_q;
  req_id_e last_d;

  // NOTE: every always_comb output gets a default first; a path that leaves
  // it unassigned would infer a latch.
  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == REQ_AUX) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign last_d = grant_o[1] ? REQ_AUX : REQ_CORE;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_AUX;
    end else if (advance_i) begin
      last_q <= last_d;
    end
  end

`endif

  assign grant_id_o = grant_o[1] ? REQ_AUX : REQ_CORE;

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one registered ALU between requester 0 (core control) and
//   requester 1 (address/aux unit). Each accepted operation is issued to the
//   ALU for exactly one cycle, the result is captured after the ALU's
//   one-cycle latency and returned as a tagged response over valid/ready.
//   Handshake at cycle T -> alu_enable at T+1 -> capture at T+2 ->
//   resp_valid at T+3.
//
//   Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
//   wins ties) instead of round-robin.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqX_valid/ready              request handshake, X = 0/1
//   reqX_mode/a/b     [N-1:0]     opcode and operands, sampled at handshake
//   resp_valid/ready              response handshake
//   resp_id                       requester that owns the response
//   resp_data         [N-1:0]     ALU result
//   resp_zero, resp_carry         result flags (carry only for ADD/SUB)
//   alu_enable/mode/a/b           drive the shared ALU
//   alu_out, alu_zero, alu_carry  ALU result and flags
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_mode,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_mode,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,

  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_data,
  output logic         resp_zero,
  output logic         resp_carry,

  output logic         alu_enable,
  output logic [N-1:0] alu_mode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_carry
);

  arb_state_e   state_q, state_d;
  logic [N-1:0] mode_q, a_q, b_q;
  req_id_e      id_q;
  logic [N-1:0] data_q;
  logic         zero_q, carry_q;

  logic [1:0]   grant;
  req_id_e      grant_id;
  logic         in_idle;
  logic         accept;
  logic         mode_is_arith;

  // Combinational outputs are masked by rst so they show reset values
  // during the reset cycle itself, whatever state was left behind.
  assign in_idle = (state_q == ST_IDLE) && !rst;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid_i    ({req1_valid, req0_valid}),
    .advance_i  (accept),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  // A grant is only ever given to a valid requester, so ready implies the
  // handshake completes this cycle.
  assign req0_ready = in_idle && grant[0];
  assign req1_ready = in_idle && grant[1];
  assign accept     = req0_ready || req1_ready;

  // The ALU leaves its carry untouched on logic ops, so the stale flag must
  // not leak into the response.
  assign mode_is_arith = (mode_q == N'(OP_ADD)) || (mode_q == N'(OP_SUB));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (resp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= REQ_CORE;
      data_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        mode_q <= req1_ready ? req1_mode : req0_mode;
        a_q    <= req1_ready ? req1_a    : req0_a;
        b_q    <= req1_ready ? req1_b    : req0_b;
        id_q   <= grant_id;
      end

      // Capture only here: any ALU result left over from an aborted
      // operation is never observed.
      if (state_q == ST_CAPTURE) begin
        data_q  <= alu_out;
        zero_q  <= alu_zero;
        carry_q <= mode_is_arith && alu_carry;
      end
    end
  end

  assign alu_enable = (state_q == ST_ISSUE) && !rst;
  assign alu_mode   = mode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

  assign resp_valid = (state_q == ST_RESP) && !rst;
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_zero  = zero_q;
  assign resp_carry = carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Bench for alu_arbiter. Provides a behavioural registered ALU on the
//   alu_* ports and predicts grants and responses from the arbitration and
//   ALU rules. Honors ALU_ARB_FIXED_PRIO_EN for the grant prediction.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 8;
  localparam logic [N-1:0] M_ADD = N'(OP_ADD);
  localparam logic [N-1:0] M_SUB = N'(OP_SUB);
  localparam logic [N-1:0] M_AND = N'(OP_AND);
  localparam logic [N-1:0] M_OR  = N'(OP_OR);
  localparam logic [N-1:0] M_XOR = N'(OP_XOR);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_mode = '0, req0_a = '0, req0_b = '0;
  logic [N-1:0] req1_mode = '0, req1_a = '0, req1_b = '0;
  logic         resp_valid, resp_id, resp_zero, resp_carry;
  logic         resp_ready = 1'b0;
  logic [N-1:0] resp_data;
  logic         alu_enable;
  logic [N-1:0] alu_mode, alu_a, alu_b;
  logic [N-1:0] alu_out = '0;
  logic         alu_zero = 1'b0, alu_carry = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_last = 1;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_mode  (req0_mode),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_mode  (req1_mode),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .resp_carry (resp_carry),
    .alu_enable (alu_enable),
    .alu_mode   (alu_mode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry)
  );

  // Returns {carry_or_borrow, result}; unknown opcodes give zero.
  function automatic logic [N:0] ref_calc(input logic [N-1:0] m, a, b);
    int unsigned ai = 32'(a);
    int unsigned bi = 32'(b);
    case (32'(m))
      OP_ADD:  return (N+1)'(ai + bi);
      OP_SUB:  return {ai < bi, N'(ai - bi)};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return '0;
    endcase
  endfunction

  function automatic logic is_arith(input logic [N-1:0] m);
    return (32'(m) == OP_ADD) || (32'(m) == OP_SUB);
  endfunction

  // Behavioural registered ALU: one-cycle latency, carry only on ADD/SUB.
  logic [N:0] alu_calc;
  assign alu_calc = ref_calc(alu_mode, alu_a, alu_b);
  always @(posedge clk) begin
    if (alu_enable) begin
      alu_out  <= alu_calc[N-1:0];
      alu_zero <= (alu_calc[N-1:0] == '0);
      if (is_arith(alu_mode)) alu_carry <= alu_calc[N];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE. Presents the
  // requests, checks the grant and the full ISSUE/CAPTURE/RESP sequence,
  // stalls the response for 'stall' cycles and then accepts it.
  task automatic run_op(input bit v0, input logic [N-1:0] m0, a0, b0,
                        input bit v1, input logic [N-1:0] m1, a1, b1,
                        input int stall);
    int n;
    int exp_id;
    logic [N-1:0] em, ea, eb, ed;
    logic [N:0]   r;
    logic         ec;

    req0_valid = v0; req0_mode = m0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_mode = m1; req1_a = a1; req1_b = b1;
    @(negedge clk);
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("grant_timeout", 32'(req0_ready || req1_ready), 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    check("both_ready", 32'(req0_ready && req1_ready), 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_id = v0 ? 0 : 1;
`else
    if (v0 && v1) exp_id = (exp_last == 1) ? 0 : 1;
    else          exp_id = v0 ? 0 : 1;
`endif
    exp_last = exp_id;
    check("grant_id", 32'(req1_ready), exp_id);

    em = (exp_id == 1) ? m1 : m0;
    ea = (exp_id == 1) ? a1 : a0;
    eb = (exp_id == 1) ? b1 : b0;
    r  = ref_calc(em, ea, eb);
    ed = r[N-1:0];
    ec = is_arith(em) ? r[N] : 1'b0;

    @(posedge clk); #1;
    if (exp_id == 0) req0_valid = 1'b0;
    else             req1_valid = 1'b0;

    @(negedge clk);  // ISSUE
    check("issue_enable", 32'(alu_enable), 1);
    check("issue_mode",   32'(alu_mode), 32'(em));
    check("issue_a",      32'(alu_a), 32'(ea));
    check("issue_b",      32'(alu_b), 32'(eb));
    check("issue_ready",  32'(req0_ready || req1_ready), 0);
    check("issue_rvalid", 32'(resp_valid), 0);

    @(negedge clk);  // CAPTURE
    check("cap_enable", 32'(alu_enable), 0);
    check("cap_rvalid", 32'(resp_valid), 0);

    @(negedge clk);  // RESP
    check("resp_valid", 32'(resp_valid), 1);
    check("resp_id",    32'(resp_id), exp_id);
    check("resp_data",  32'(resp_data), 32'(ed));
    check("resp_zero",  32'(resp_zero), 32'(ed == '0));
    check("resp_carry", 32'(resp_carry), 32'(ec));

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid",  32'(resp_valid), 1);
      check("stall_data",   32'(resp_data), 32'(ed));
      check("stall_id",     32'(resp_id), exp_id);
      check("stall_carry",  32'(resp_carry), 32'(ec));
      check("stall_ready",  32'(req0_ready || req1_ready), 0);
      check("stall_enable", 32'(alu_enable), 0);
    end

    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int v;
    int sel;
    logic [N-1:0] m0, m1;

    // Reset, with a request present to show ready is held low.
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_rvalid", 32'(resp_valid), 0);
    check("rst_enable", 32'(alu_enable), 0);
    check("rst_data",   32'(resp_data), 0);
    check("rst_mode",   32'(alu_mode), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;

    // Tie after reset: requester 0 first, then requester 1.
    run_op(1'b1, M_SUB, 8'h05, 8'h05, 1'b1, M_OR, 8'h0F, 8'hF0, 0);
    run_op(1'b0, M_SUB, 8'h05, 8'h05, 1'b1, M_OR, 8'h0F, 8'hF0, 0);

    // Requester 0 alone: ADD with carry out.
    run_op(1'b1, M_ADD, 8'hF0, 8'h20, 1'b0, '0, '0, '0, 0);

    // Both requesters held valid for four operations.
    for (int i = 0; i < 4; i++)
      run_op(1'b1, M_ADD, N'(i), 8'h10, 1'b1, M_XOR, N'(i), 8'h3C, 0);

    // Stale ALU carry must not reach a logic-op response.
    run_op(1'b1, M_ADD, 8'hFF, 8'h01, 1'b0, '0, '0, '0, 0);
    run_op(1'b1, M_AND, 8'hFF, 8'h00, 1'b0, '0, '0, '0, 0);

    // Unknown opcode and a five-cycle response stall.
    run_op(1'b0, '0, '0, '0, 1'b1, 8'hC7, 8'h12, 8'h34, 5);

    // Reset while the operation is in CAPTURE.
    req0_valid = 1'b1; req0_mode = M_ADD; req0_a = 8'h12; req0_b = 8'h34;
    @(negedge clk);
    n = 0;
    while (!req0_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rr_grant", 32'(req0_ready), 1);
    @(posedge clk); #1;   // ISSUE
    req0_valid = 1'b0;
    @(posedge clk); #1;   // CAPTURE
    rst = 1'b1;
    @(negedge clk);
    check("rr_in_rvalid", 32'(resp_valid), 0);
    check("rr_in_enable", 32'(alu_enable), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last = 1;
    @(negedge clk);
    check("rr_rvalid", 32'(resp_valid), 0);
    check("rr_id",     32'(resp_id), 0);
    check("rr_data",   32'(resp_data), 0);
    check("rr_zero",   32'(resp_zero), 0);
    check("rr_carry",  32'(resp_carry), 0);
    check("rr_enable", 32'(alu_enable), 0);
    check("rr_mode",   32'(alu_mode), 0);
    check("rr_a",      32'(alu_a), 0);
    check("rr_b",      32'(alu_b), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_no_resp", 32'(resp_valid), 0);
    end
    @(posedge clk); #1;
    run_op(1'b1, M_XOR, 8'hAA, 8'h55, 1'b0, '0, '0, '0, 0);

    // Randomized operations, including unknown opcodes and stalls.
    for (int i = 0; i < 40; i++) begin
      v   = int'($urandom_range(1, 3));
      sel = int'($urandom_range(0, 9));
      m0  = (sel < 8) ? N'(sel) : N'($urandom);
      sel = int'($urandom_range(0, 9));
      m1  = (sel < 8) ? N'(sel) : N'($urandom);
      run_op(v[0], m0, N'($urandom), N'($urandom),
             v[1], m1, N'($urandom), N'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single registered `alu` instance between two requesters (0 = core control, 1 = address/aux unit).
- Arbitrates requests and drives `alu` enable/mode/operands for exactly one cycle per operation.
- Captures result and flags after the ALU's one-cycle registered latency.
- Returns a tagged response over a valid/ready handshake.
- Only block allowed to drive `alu` inputs.

Parameters:
- N, 8, datapath width; must equal the `alu` N.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_mode  in  N  opcode (OP_ADD/SUB/AND/OR/XOR)
- req0_a, req0_b  in  N each  operands
- req1_valid, req1_ready, req1_mode, req1_a, req1_b  as above, requester 1
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester the response belongs to
- resp_data  out  N  ALU result
- resp_zero  out  1  result == 0
- resp_carry  out  1  carry/borrow; 0 for logic ops
- alu_enable  out  1  to alu.enable
- alu_mode  out  N  to alu.mode
- alu_a, alu_b  out  N each  to alu.in_a / in_b
- alu_out  in  N  from alu.out
- alu_zero, alu_carry  in  1 each  from alu.flag_zero / flag_carry

Behaviour:
- FSM states and transitions:
  - IDLE: req_ready asserted to the winner only. On handshake, latch mode/a/b/id, go to ISSUE.
  - ISSUE: alu_enable=1 for exactly one cycle, driving latched mode/a/b. Go to CAPTURE.
  - CAPTURE: alu_out/flags are valid this cycle. Latch resp_data, resp_zero, resp_carry. Go to RESP.
  - RESP: resp_valid=1; all resp_* fields stable. On resp_valid&resp_ready, go to IDLE.
- Latency: handshake at cycle T gives resp_valid at T+3. Back-to-back throughput is one op per 4 cycles minimum.
- Arbitration (default): round-robin.
  - Pointer `last` updated on each grant; on simultaneous valid, the requester not granted last wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- req_ready is asserted only in IDLE, to one requester, combinationally from valids and `last`. It is never asserted to both.
- Carry: alu_carry is only updated by the ALU on ADD/SUB. resp_carry = alu_carry if latched mode is OP_ADD or OP_SUB, else 0.
- Unknown opcode: passed through unchanged. ALU yields 0, so resp_data=0, resp_zero=1, resp_carry=0. No error signalled.
- alu_enable=0 in all states except ISSUE. alu_mode/alu_a/alu_b hold latched values (0 after reset).
- Reset values: state=IDLE, all req_ready=0 during rst, resp_valid=0, resp_id=0, resp_data=0, resp_zero=0, resp_carry=0, alu_enable=0, alu_mode/a/b=0, last=1.
- Reset mid-operation: in-flight op discarded, no response. A pending ALU result is ignored because capture only occurs in CAPTURE.
- Requester deasserting valid before handshake: legal, no effect. Operands are sampled only at handshake.
- resp_ready low in RESP: stall indefinitely; no new grants.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins ties; `last` register omitted.
- Undefined: round-robin as above.

Decomposition:
- Opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR) come from the shared parameters include.
- Add an FSM state enum type and a requester-id type there.
- One natural sub-module: `rr_arbiter2` (2-way round-robin grant with last-pointer; fixed-priority under the macro). The rest stays flat.

Test Plan:
- Req0 ADD a=0xF0 b=0x20 alone -> req0_ready at T, alu_enable high only at T+1, resp_valid at T+3 with id=0, data=0x10, carry=1, zero=0.
- Both valid, SUB 0x05-0x05 on req0 and OR 0x0F|0xF0 on req1 -> req0 first: data=0x00, zero=1, carry=0. Then req1: data=0xFF, carry=0.
- Both held valid for 4 ops -> grants alternate 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
- ADD 0xFF+0x01 then AND 0xFF&0x00 -> first carry=1, second resp_carry=0 even though alu_carry still 1.
- resp_ready low for 5 cycles in RESP -> resp_* stable, no req_ready, alu_enable stays 0.
- rst asserted in CAPTURE -> next cycle all outputs at reset values, no response emitted; a fresh XOR 0xAA^0x55 then returns 0xFF.
